// File: rtl/fxp_mul_pipe.sv
// Signed fixed-point multiplier, Q(WIDTH-FRAC).FRAC, with optional round-half-up and saturation.
// Latency: STAGES cycles from input transfer to valid_o, one result per cycle sustained.
// Backpressure: valid/ready with bubble collapsing; ready_o drops only when every stage is full and ready_i=0.
module fxp_mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int STAGES = 2,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] c_o,
    output logic             ovf_o
);

    // One spare bit above the full product so the rounding add can never wrap.
    localparam int PW = 2 * WIDTH + 1;
    localparam logic signed [PW-1:0] RND_INC =
        (ROUND != 0 && FRAC > 0) ? (PW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shf;
    logic [WIDTH-1:0]     res_dat;
    logic                 res_ovf;

    always_comb begin
        prod    = PW'($signed(a_i)) * PW'($signed(b_i));
        shf     = (prod + RND_INC) >>> FRAC;
        // Out of range whenever the shifted value differs from its own WIDTH-bit sign extension.
        res_ovf = (shf != PW'($signed(shf[WIDTH-1:0])));
        res_dat = shf[WIDTH-1:0];
        if (SAT != 0 && res_ovf) begin
            res_dat = shf[PW-1] ? MIN_NEG : MAX_POS;
        end
    end

    logic [STAGES-1:0] stg_vld;
    logic [STAGES-1:0] stg_ovf;
    logic [WIDTH-1:0]  stg_dat [STAGES];
    logic [STAGES:0]   adv;

    // A stage advances if it is empty or its successor advances; the top bit is the output transfer.
    always_comb begin
        adv         = '0;
        adv[STAGES] = ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !stg_vld[k] || adv[k+1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stg_vld <= '0;
            stg_ovf <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_dat[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                stg_vld[0] <= valid_i;
                if (valid_i) begin
                    stg_dat[0] <= res_dat;
                    stg_ovf[0] <= res_ovf;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    stg_vld[k] <= stg_vld[k-1];
                    if (stg_vld[k-1]) begin
                        stg_dat[k] <= stg_dat[k-1];
                        stg_ovf[k] <= stg_ovf[k-1];
                    end
                end
            end
        end
    end

    assign ready_o = adv[0];
    assign valid_o = stg_vld[STAGES-1];
    assign c_o     = stg_dat[STAGES-1];
    assign ovf_o   = stg_ovf[STAGES-1];

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Bench for fxp_mul_pipe: a round/saturate instance and a truncate/wrap instance share stimulus
// and flow control; results are compared against an integer-arithmetic reference and fixed vectors.
module tb_fxp_mul_pipe;

    localparam int W  = 32;
    localparam int F  = 16;
    localparam int ST = 2;
    localparam longint MAXV = 64'sh7fffffff;
    localparam longint MINV = -64'sh80000000;

    // Directed vectors: operands, then expected (c, ovf) for round+sat and for trunc+wrap.
    localparam logic [31:0] DA [7] = '{32'h00018000, 32'hFFFE8000, 32'h7FFF0000, 32'h00000001,
                                       32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    localparam logic [31:0] DB [7] = '{32'h00020000, 32'h00020000, 32'h00020000, 32'h00008000,
                                       32'h80000000, 32'h00020000, 32'h00008000};
    localparam logic [31:0] DCS [7] = '{32'h00030000, 32'hFFFD0000, 32'h7FFFFFFF, 32'h00000001,
                                        32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    localparam logic [31:0] DCW [7] = '{32'h00030000, 32'hFFFD0000, 32'hFFFE0000, 32'h00000000,
                                        32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    localparam logic DOV [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, valid_i, ready_i;
    logic [W-1:0]  a, b;
    logic          rdy_s, vld_s, ovf_s, rdy_w, vld_w, ovf_w;
    logic [W-1:0]  c_s, c_w;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] cs;
        logic        os;
        logic [31:0] cw;
        logic        ow;
    } exp_t;
    exp_t q[$];

    fxp_mul_pipe #(.WIDTH(W), .FRAC(F), .STAGES(ST), .ROUND(1), .SAT(1)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(rdy_s),
        .a_i(a), .b_i(b), .valid_o(vld_s), .ready_i(ready_i), .c_o(c_s), .ovf_o(ovf_s)
    );

    fxp_mul_pipe #(.WIDTH(W), .FRAC(F), .STAGES(ST), .ROUND(0), .SAT(0)) dut_w (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(rdy_w),
        .a_i(a), .b_i(b), .valid_o(vld_w), .ready_i(ready_i), .c_o(c_w), .ovf_o(ovf_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact 64-bit integer product, scaled back by FRAC, then range-checked.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input bit rnd, input bit sat,
                         output logic [31:0] c, output logic o);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        if (rnd) p = p + 64'sd32768;
        p = p >>> F;
        o = (p > MAXV) || (p < MINV);
        if (o && sat) c = (p < 0) ? 32'h80000000 : 32'h7FFFFFFF;
        else          c = p[31:0];
    endtask

    task automatic rand_ops();
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 2))
            0: begin a = {{12{a[19]}}, a[19:0]}; b = {{12{b[19]}}, b[19:0]}; end
            1: begin a = {{8{a[23]}}, a[23:0]}; end
            default: begin if ($urandom_range(0, 1) == 1) a = 32'h80000000; end
        endcase
    endtask

    task automatic send_directed(input int idx);
        @(negedge clk);
        a = DA[idx]; b = DB[idx]; valid_i = 1'b1; ready_i = 1'b1;
        #1 chk($sformatf("dir%0d_ready_o", idx), 64'(rdy_s), 64'(1));
        for (int i = 1; i <= ST; i++) begin
            @(negedge clk);
            if (i == 1) valid_i = 1'b0;
            if (i < ST) chk($sformatf("dir%0d_early_valid", idx), 64'(vld_s), 64'(0));
        end
        chk($sformatf("dir%0d_valid_s", idx), 64'(vld_s), 64'(1));
        chk($sformatf("dir%0d_c_sat", idx), 64'(c_s), 64'(DCS[idx]));
        chk($sformatf("dir%0d_ovf_sat", idx), 64'(ovf_s), 64'(DOV[idx]));
        chk($sformatf("dir%0d_valid_w", idx), 64'(vld_w), 64'(1));
        chk($sformatf("dir%0d_c_wrap", idx), 64'(c_w), 64'(DCW[idx]));
        chk($sformatf("dir%0d_ovf_wrap", idx), 64'(ovf_w), 64'(DOV[idx]));
    endtask

    initial begin
        int   sent, got, burst, cyc;
        bit   hold, last_in;
        logic [31:0] hold_cs, hold_cw;
        logic hold_os;
        exp_t e;

        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_valid_o", 64'(vld_s), 64'(0));
        chk("rst_c_o", 64'(c_s), 64'(0));
        chk("rst_ovf_o", 64'(ovf_s), 64'(0));
        chk("rst_ready_o", 64'(rdy_s), 64'(1));
        chk("rst_valid_o_w", 64'(vld_w), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) send_directed(i);

        // Random stream with backpressure bursts.
        sent = 0; got = 0; burst = 0; cyc = 0; hold = 1'b0; last_in = 1'b0;
        rand_ops();
        while ((sent < 20 || q.size() > 0) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                chk("hold_valid_o", 64'(vld_s), 64'(1));
                chk("hold_c_sat", 64'(c_s), 64'(hold_cs));
                chk("hold_ovf_sat", 64'(ovf_s), 64'(hold_os));
                chk("hold_c_wrap", 64'(c_w), 64'(hold_cw));
            end
            if (last_in) rand_ops();
            if (burst > 0) begin
                ready_i = 1'b0; burst--;
            end else if (cyc == 4 || cyc == 18 || cyc == 33) begin
                ready_i = 1'b0; burst = 4;
            end else begin
                ready_i = 1'($urandom_range(0, 1));
            end
            valid_i = (sent < 20);
            #1;
            chk("stream_ready_o", 64'(rdy_s), 64'(!(q.size() == ST && !ready_i)));
            chk("stream_ready_o_w", 64'(rdy_w), 64'(!(q.size() == ST && !ready_i)));
            if (vld_s && ready_i) begin
                chk("stream_result_expected", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk($sformatf("stream%0d_c_sat", got), 64'(c_s), 64'(e.cs));
                    chk($sformatf("stream%0d_ovf_sat", got), 64'(ovf_s), 64'(e.os));
                    chk($sformatf("stream%0d_c_wrap", got), 64'(c_w), 64'(e.cw));
                    chk($sformatf("stream%0d_ovf_wrap", got), 64'(ovf_w), 64'(e.ow));
                    got++;
                end
            end
            hold    = vld_s && !ready_i;
            hold_cs = c_s; hold_os = ovf_s; hold_cw = c_w;
            last_in = valid_i && rdy_s;
            if (last_in) begin
                model(a, b, 1'b1, 1'b1, e.cs, e.os);
                model(a, b, 1'b0, 1'b0, e.cw, e.ow);
                q.push_back(e);
                sent++;
            end
        end
        chk("stream_results", 64'(got), 64'(20));
        chk("stream_queue_empty", 64'(q.size()), 64'(0));

        // Reset with two results in flight.
        @(negedge clk);
        a = 32'h00018000; b = 32'h00020000; valid_i = 1'b1; ready_i = 1'b0;
        repeat (2) @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("inflight_valid_o", 64'(vld_s), 64'(1));
        chk("inflight_full_ready_o", 64'(rdy_s), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid_o", 64'(vld_s), 64'(0));
        chk("midrst_c_o", 64'(c_s), 64'(0));
        chk("midrst_ovf_o", 64'(ovf_s), 64'(0));
        chk("midrst_ready_o", 64'(rdy_s), 64'(1));
        chk("midrst_valid_o_w", 64'(vld_w), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst_no_stale", 64'(vld_s), 64'(0));
        end
        send_directed(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
